// File: rtl/fir_pkg.sv
// Shared sizing helpers and lane-slice macro for the unrolled FIR.
// Sizing: ACC_W = 2*NB + clog2(NT+1) so the tap sum can never overflow.
`ifndef FIR_PKG_SV
`define FIR_PKG_SV

`define FIR_SLICE(vec, idx, w) vec[(idx)*(w) +: (w)]

package fir_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    function automatic int acc_w(input int nb, input int nt);
        return 2 * nb + clog2(nt + 1);
    endfunction

endpackage

`endif

// File: rtl/fir_lane_mac.sv
// One output lane: combinational sum of NT+1 signed NBxNB products.
// taps_i slice i holds x[n-i]; coef_i slice i holds b_i.
module fir_lane_mac
    import fir_pkg::*;
#(
    parameter int NB = 8,
    parameter int NT = 10
) (
    input  logic [(NT+1)*NB-1:0]    taps_i,
    input  logic [(NT+1)*NB-1:0]    coef_i,
    output logic [acc_w(NB,NT)-1:0] acc_o
);

    localparam int ACC_W = acc_w(NB, NT);
    localparam int PW    = 2 * NB;

    logic [PW-1:0] xs;
    logic [PW-1:0] bs;
    logic [PW-1:0] prod;

    // Operands are sign-extended to 2*NB so the unsigned product's low bits equal the signed product.
    always_comb begin
        xs    = '0;
        bs    = '0;
        prod  = '0;
        acc_o = '0;
        for (int i = 0; i <= NT; i++) begin
            xs    = {{NB{taps_i[i*NB+NB-1]}}, `FIR_SLICE(taps_i, i, NB)};
            bs    = {{NB{coef_i[i*NB+NB-1]}}, `FIR_SLICE(coef_i, i, NB)};
            prod  = xs * bs;
            acc_o = acc_o + {{(ACC_W-PW){prod[PW-1]}}, prod};
        end
    end

endmodule

// File: rtl/fir_unrolled_param.sv
// L-lane unrolled direct-form FIR, two-stage pipeline (input/delay-line regs, then output regs).
// Build option FIR_SAT_EN: saturate the NB-bit reduction and add the SAT output; otherwise wrap.
module fir_unrolled_param
    import fir_pkg::*;
#(
    parameter int NB    = 8,
    parameter int NT    = 10,
    parameter int LANES = 3
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [(NT+1)*NB-1:0]  B,
    input  logic [LANES*NB-1:0]   DIN,
    input  logic                  VIN,
    output logic [LANES*NB-1:0]   DOUT,
    output logic                  VOUT
`ifdef FIR_SAT_EN
    ,
    output logic                  SAT
`endif
);

    localparam int ACC_W = acc_w(NB, NT);
    localparam int SHR_W = ACC_W - NB + 1;
    localparam int WIN   = NT + LANES;
    localparam logic signed [SHR_W-1:0] MAXV = SHR_W'((1 << (NB - 1)) - 1);
    localparam logic signed [SHR_W-1:0] MINV = ~MAXV;

    logic [LANES*NB-1:0] din_q;
    logic [NT*NB-1:0]    hist_q;
    logic                v1_q;
    logic                vout_q;
    logic [LANES*NB-1:0] dout_q;
    logic [LANES*NB-1:0] dout_d;
    logic [WIN*NB-1:0]   win;

    // Time-ordered window, oldest at slice 0: NT past samples followed by the current group.
    assign win = {din_q, hist_q};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            din_q  <= '0;
            hist_q <= '0;
            v1_q   <= 1'b0;
        end else begin
            v1_q <= VIN;
            if (VIN) begin
                din_q  <= DIN;
                hist_q <= win[LANES*NB +: NT*NB];
            end
        end
    end

`ifdef FIR_SAT_EN
    logic [LANES-1:0] sat_lane;
    logic             sat_q;
`endif

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [(NT+1)*NB-1:0]    taps;
        logic [ACC_W-1:0]        acc;
        logic signed [SHR_W-1:0] shr;
        logic                    lane_unused;

        always_comb begin
            taps = '0;
            for (int i = 0; i <= NT; i++) begin
                `FIR_SLICE(taps, i, NB) = `FIR_SLICE(win, NT + k - i, NB);
            end
        end

        fir_lane_mac #(
            .NB (NB),
            .NT (NT)
        ) u_mac (
            .taps_i (taps),
            .coef_i (B),
            .acc_o  (acc)
        );

        // Dropping the low NB-1 bits is the arithmetic shift (floor toward -inf).
        assign shr = acc[ACC_W-1:NB-1];

`ifdef FIR_SAT_EN
        assign lane_unused = ^acc[NB-2:0];
        always_comb begin
            `FIR_SLICE(dout_d, k, NB) = shr[NB-1:0];
            sat_lane[k]               = 1'b0;
            if (shr > MAXV) begin
                `FIR_SLICE(dout_d, k, NB) = MAXV[NB-1:0];
                sat_lane[k]               = 1'b1;
            end else if (shr < MINV) begin
                `FIR_SLICE(dout_d, k, NB) = MINV[NB-1:0];
                sat_lane[k]               = 1'b1;
            end
        end
`else
        assign lane_unused = ^{acc[NB-2:0], shr[SHR_W-1:NB], MAXV, MINV};
        assign `FIR_SLICE(dout_d, k, NB) = shr[NB-1:0];
`endif
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dout_q <= '0;
            vout_q <= 1'b0;
        end else begin
            vout_q <= v1_q;
            if (v1_q) dout_q <= dout_d;
        end
    end

`ifdef FIR_SAT_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)       sat_q <= 1'b0;
        else if (v1_q) sat_q <= |sat_lane;
    end
    assign SAT = sat_q;
`endif

    assign DOUT = dout_q;
    assign VOUT = vout_q;

endmodule

// File: tb/tb_fir_unrolled_param.sv
// Scoreboard bench for fir_unrolled_param: a serial reference FIR predicts every output lane.
// Also builds with FIR_SAT_EN to check the saturating variant and SAT.
module tb_fir_unrolled_param;

    localparam int NB    = 8;
    localparam int NT    = 10;
    localparam int LANES = 3;

    logic                 CLK = 1'b0;
    logic                 RST;
    logic [(NT+1)*NB-1:0] B;
    logic [LANES*NB-1:0]  DIN;
    logic                 VIN;
    logic [LANES*NB-1:0]  DOUT;
    logic                 VOUT;
`ifdef FIR_SAT_EN
    logic                 SAT;
    bit                   satq[$];
    bit                   satcap[$];
`endif

    int coef[NT+1] = '{-1, -2, -4, 8, 35, 50, 35, 8, -4, -2, -1};
    int xs[$];
    int expq[$];
    int cap[$];
    int pass_cnt  = 0;
    int total_cnt = 0;
    int vin_cnt   = 0;
    int vout_cnt  = 0;
    logic [LANES*NB-1:0] last_dout;

    always #5 CLK = ~CLK;

    fir_unrolled_param #(
        .NB    (NB),
        .NT    (NT),
        .LANES (LANES)
    ) dut (
        .CLK  (CLK),
        .RST  (RST),
        .B    (B),
        .DIN  (DIN),
        .VIN  (VIN),
        .DOUT (DOUT),
        .VOUT (VOUT)
`ifdef FIR_SAT_EN
        ,
        .SAT  (SAT)
`endif
    );

    function automatic int model_y(input int n, output bit sat);
        int acc;
        int shr;
        int y;
        acc = 0;
        sat = 1'b0;
        for (int i = 0; i <= NT; i++) begin
            if (n - i >= 0) acc += coef[i] * xs[n-i];
        end
        shr = acc >>> (NB - 1);
`ifdef FIR_SAT_EN
        y = shr;
        if (shr > 127) begin
            y = 127;
            sat = 1'b1;
        end else if (shr < -128) begin
            y = -128;
            sat = 1'b1;
        end
`else
        y = shr & 255;
        if (y > 127) y -= 256;
`endif
        return y;
    endfunction

    task automatic send(input bit v, input int s0, input int s1, input int s2);
        int  s_arr[LANES];
        int  y;
        bit  s;
        bit  sat_any;
        s_arr   = '{s0, s1, s2};
        sat_any = 1'b0;
        @(negedge CLK);
        VIN = v;
        for (int k = 0; k < LANES; k++) DIN[k*NB +: NB] = s_arr[k][NB-1:0];
        if (v) begin
            vin_cnt++;
            for (int k = 0; k < LANES; k++) begin
                xs.push_back(s_arr[k]);
                y = model_y(xs.size() - 1, s);
                sat_any |= s;
                expq.push_back(y);
            end
`ifdef FIR_SAT_EN
            satq.push_back(sat_any);
`endif
        end
    endtask

    task automatic clear_model();
        xs.delete();
        expq.delete();
`ifdef FIR_SAT_EN
        satq.delete();
`endif
    endtask

    task automatic do_reset();
        RST = 1'b1;
        VIN = 1'b0;
        clear_model();
        repeat (2) @(negedge CLK);
        #2 RST = 1'b0;
    endtask

    // Scoreboard: every valid output group is popped and compared; DOUT must hold while VOUT=0.
    always @(negedge CLK) begin
        logic signed [NB-1:0] g;
        int e;
        if (RST) begin
            last_dout = '0;
        end else begin
            if (VOUT) begin
                vout_cnt++;
                for (int k = 0; k < LANES; k++) begin
                    g = DOUT[k*NB +: NB];
                    total_cnt++;
                    if (expq.size() == 0) begin
                        $display("FAIL sb_lane%0d: unexpected output %0d, no group expected", k, int'(g));
                    end else begin
                        e = expq.pop_front();
                        if (int'(g) !== e)
                            $display("FAIL sb_lane%0d: got %0d expected %0d", k, int'(g), e);
                        else
                            pass_cnt++;
                    end
                    cap.push_back(int'(g));
                end
`ifdef FIR_SAT_EN
                total_cnt++;
                if (satq.size() == 0) begin
                    $display("FAIL sb_sat: unexpected SAT=%0b", SAT);
                end else begin
                    e = int'(satq.pop_front());
                    if (int'(SAT) !== e) $display("FAIL sb_sat: got %0b expected %0d", SAT, e);
                    else pass_cnt++;
                end
                satcap.push_back(SAT);
`endif
            end else begin
                total_cnt++;
                if (DOUT !== last_dout)
                    $display("FAIL dout_hold: got %h expected %h", DOUT, last_dout);
                else
                    pass_cnt++;
            end
            last_dout = DOUT;
        end
    end

    task automatic test_reset();
        RST = 1'b1;
        VIN = 1'b1;
        DIN = 24'h7f_7f_7f;
        repeat (2) @(negedge CLK);
        total_cnt++;
        if (DOUT !== '0) $display("FAIL reset_dout: got %h expected 0", DOUT);
        else pass_cnt++;
        total_cnt++;
        if (VOUT !== 1'b0) $display("FAIL reset_vout: got %b expected 0", VOUT);
        else pass_cnt++;
`ifdef FIR_SAT_EN
        total_cnt++;
        if (SAT !== 1'b0) $display("FAIL reset_sat: got %b expected 0", SAT);
        else pass_cnt++;
`endif
        VIN = 1'b0;
        clear_model();
        #2 RST = 1'b0;
        repeat (3) send(0, 0, 0, 0);
        total_cnt++;
        if (VOUT !== 1'b0) $display("FAIL idle_vout: got %b expected 0", VOUT);
        else pass_cnt++;
    endtask

    task automatic test_impulse();
        int imp[11];
        int e;
        imp = '{-1, -2, -4, 7, 34, 49, 34, 7, -4, -2, -1};
        cap.delete();
        send(1, 127, 0, 0);
        repeat (4) send(1, 0, 0, 0);
        repeat (3) send(0, 0, 0, 0);
        total_cnt++;
        if (cap.size() != 15) begin
            $display("FAIL impulse_len: got %0d samples expected 15", cap.size());
        end else begin
            pass_cnt++;
            for (int j = 0; j < 15; j++) begin
                e = (j < 11) ? imp[j] : 0;
                total_cnt++;
                if (cap[j] !== e) $display("FAIL impulse_y%0d: got %0d expected %0d", j, cap[j], e);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_step();
        do_reset();
        cap.delete();
        repeat (6) send(1, 127, 127, 127);
        repeat (3) send(0, 0, 0, 0);
        total_cnt++;
        if (cap.size() != 18) begin
            $display("FAIL step_len: got %0d samples expected 18", cap.size());
        end else begin
            pass_cnt++;
            // Steady state: sum(b) = 122, floor(122*127/128) = 121.
            for (int j = 10; j < 18; j++) begin
                total_cnt++;
                if (cap[j] !== 121) $display("FAIL step_y%0d: got %0d expected 121", j, cap[j]);
                else pass_cnt++;
            end
        end
    endtask

    task automatic test_overflow();
        int e;
        do_reset();
        cap.delete();
`ifdef FIR_SAT_EN
        satcap.delete();
        e = 127;
`else
        e = -108;
`endif
        send(1, 0, -127, -127);
        send(1, -127, 127, 127);
        send(1, 127, 127, 127);
        send(1, -127, -127, -127);
        repeat (3) send(0, 0, 0, 0);
        total_cnt++;
        if (cap.size() != 12) begin
            $display("FAIL ovf_len: got %0d samples expected 12", cap.size());
        end else begin
            pass_cnt++;
            total_cnt++;
            if (cap[11] !== e) $display("FAIL ovf_y: got %0d expected %0d", cap[11], e);
            else pass_cnt++;
        end
`ifdef FIR_SAT_EN
        total_cnt++;
        if (satcap.size() != 4 || satcap[3] !== 1'b1)
            $display("FAIL ovf_sat: got %0d flags expected final SAT 1", satcap.size());
        else
            pass_cnt++;
`endif
    endtask

    task automatic test_bubbles();
        do_reset();
        vin_cnt  = 0;
        vout_cnt = 0;
        for (int c = 0; c < 80; c++) begin
            send(1'($urandom_range(0, 1)),
                 int'($urandom_range(0, 255)) - 128,
                 int'($urandom_range(0, 255)) - 128,
                 int'($urandom_range(0, 255)) - 128);
        end
        repeat (3) send(0, 0, 0, 0);
        total_cnt++;
        if (vout_cnt !== vin_cnt) $display("FAIL bubble_count: got %0d VOUT expected %0d", vout_cnt, vin_cnt);
        else pass_cnt++;
        total_cnt++;
        if (expq.size() != 0) $display("FAIL bubble_drain: got %0d pending expected 0", expq.size());
        else pass_cnt++;
    endtask

    task automatic test_reset_midstream();
        send(1, 100, -50, 25);
        send(1, -100, 60, 7);
        @(posedge CLK);
        #1 RST = 1'b1;
        VIN = 1'b0;
        #1;
        total_cnt++;
        if (VOUT !== 1'b0) $display("FAIL midrst_vout: got %b expected 0", VOUT);
        else pass_cnt++;
        total_cnt++;
        if (DOUT !== '0) $display("FAIL midrst_dout: got %h expected 0", DOUT);
        else pass_cnt++;
        clear_model();
        repeat (2) @(negedge CLK);
        #2 RST = 1'b0;
        test_impulse();
    endtask

    initial begin
        RST = 1'b1;
        VIN = 1'b0;
        DIN = '0;
        for (int i = 0; i <= NT; i++) B[i*NB +: NB] = coef[i][NB-1:0];
        test_reset();
        test_impulse();
        test_step();
        test_overflow();
        test_bubbles();
        test_reset_midstream();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
